// File: rtl/dut_stream_sequencer_pkg.sv
// Shared definitions for the DUT stream sequencer.
//  - seq_state_t : sequencer FSM states
//  - ADDR_*      : config bus register addresses
package dut_stream_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FEED    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_COLLECT = 2'd3
    } seq_state_t;

    localparam logic [7:0] ADDR_OPS  = 8'h01;
    localparam logic [7:0] ADDR_TDLY = 8'h02;
    localparam logic [7:0] ADDR_TWID = 8'h03;
    localparam logic [7:0] ADDR_TO   = 8'h04;

endpackage

// File: rtl/dut_stream_sequencer_trig_pulse_gen.sv
// Scope trigger pulse generator.
// On arm, latches delay/width and counts cycles c = 0,1,2,... starting
// with the cycle after arm. trg is high while delay <= c < delay+width.
// width = 0 produces no pulse. A new arm restarts the sequence.
//  clk, rst : clock, asynchronous active-high reset
//  arm      : 1-cycle arm strobe
//  delay    : cycles from the first post-arm cycle to the pulse
//  width    : pulse length in cycles
//  trg      : registered trigger output
module trig_pulse_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic [7:0] delay,
    input  logic [7:0] width,
    output logic       trg
);

    logic [8:0] cnt_r;
    logic [8:0] dly_r;
    logic [8:0] end_r;
    logic [8:0] cnt_nxt_s;
    logic       run_r;
    logic       trg_r;

    assign cnt_nxt_s = cnt_r + 9'd1;
    assign trg       = trg_r;

    // Delay/width sequencing; trg_r already reflects the next cycle's count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 9'd0;
            dly_r <= 9'd0;
            end_r <= 9'd0;
            run_r <= 1'b0;
            trg_r <= 1'b0;
        end else if (arm) begin
            cnt_r <= 9'd0;
            dly_r <= {1'b0, delay};
            end_r <= {1'b0, delay} + {1'b0, width};
            run_r <= (width != 8'd0);
            trg_r <= (delay == 8'd0) && (width != 8'd0);
        end else if (run_r) begin
            if (cnt_nxt_s >= end_r) begin
                run_r <= 1'b0;
                trg_r <= 1'b0;
            end else begin
                cnt_r <= cnt_nxt_s;
                trg_r <= (cnt_nxt_s >= dly_r);
            end
        end else begin
            trg_r <= 1'b0;
        end
    end

endmodule

// File: rtl/dut_stream_sequencer.sv
// Sequencer between the UART command decoder and a byte-serial crypto DUT.
// Holds NUM_IN operands, streams them lane-parallel into the DUT MSB beat
// first, collects OUT_BEATS output beats into result, drives a scope trigger
// and flags a sticky timeout when the DUT never signals done.
//  clk, rst      : clock, asynchronous active-high reset
//  cfg_we/addr/data : config bus (operands, trigger delay/width, timeout limit)
//  start         : run request pulse (ignored while busy)
//  busy          : run in progress
//  dut_start     : 1-cycle start pulse to the DUT
//  dut_in        : current beat of each operand, operand i in lane i
//  dut_done      : DUT first output beat valid
//  dut_out       : DUT output beat
//  result        : collected output, first beat in the MSBs
//  result_valid  : 1-cycle completion pulse
//  trg           : scope trigger
//  timeout       : sticky timeout flag, cleared by the next accepted start
module dut_stream_sequencer
    import dut_stream_sequencer_pkg::*;
#(
    parameter int OP_BYTES  = 16,
    parameter int NUM_IN    = 2,
    parameter int LANE_W    = 8,
    parameter int OUT_BYTES = 16,
    parameter int TO_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [7:0]                 cfg_addr,
    input  logic [NUM_IN*OP_BYTES*8-1:0] cfg_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       dut_start,
    output logic [NUM_IN*LANE_W-1:0]   dut_in,
    input  logic                       dut_done,
    input  logic [LANE_W-1:0]          dut_out,
    output logic [OUT_BYTES*8-1:0]     result,
    output logic                       result_valid,
    output logic                       trg,
    output logic                       timeout
);

    localparam int OP_W      = 8 * OP_BYTES;
    localparam int IN_W      = NUM_IN * OP_W;
    localparam int OUT_W     = 8 * OUT_BYTES;
    localparam int IN_BEATS  = OP_W / LANE_W;
    localparam int OUT_BEATS = OUT_W / LANE_W;
    localparam int IB_W      = $clog2(IN_BEATS + 1);
    localparam int OB_W      = $clog2(OUT_BEATS + 1);

    seq_state_t            state_r;
    seq_state_t            state_nxt_s;
    logic [IN_W-1:0]       ops_r;
    logic [7:0]            trg_delay_r;
    logic [7:0]            trg_width_r;
    logic [TO_W-1:0]       to_limit_r;
    logic [IN_W-1:0]       sh_r;
    logic [IB_W-1:0]       ib_cnt_r;
    logic [OB_W-1:0]       ob_cnt_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic                  busy_r;
    logic                  dut_start_r;
    logic [NUM_IN*LANE_W-1:0] dut_in_r;
    logic [OUT_W-1:0]      result_r;
    logic                  result_valid_r;
    logic                  timeout_r;
    logic                  start_acc_s;
    logic                  cfg_acc_s;
    logic                  feed_last_s;
    logic                  to_hit_s;
    logic                  col_last_s;

    // Next-state logic and run-control decodes
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = (state_r == ST_IDLE) && start;
        cfg_acc_s   = (state_r == ST_IDLE) && cfg_we;
        feed_last_s = (ib_cnt_r == IB_W'(IN_BEATS - 1));
        col_last_s  = (ob_cnt_r == OB_W'(OUT_BEATS - 1));
        to_hit_s    = (to_limit_r != {TO_W{1'b0}}) && (to_cnt_r >= to_limit_r);
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) state_nxt_s = ST_FEED;
                else             state_nxt_s = ST_IDLE;
            end
            ST_FEED: begin
                if (feed_last_s) state_nxt_s = ST_WAIT;
                else             state_nxt_s = ST_FEED;
            end
            ST_WAIT: begin
                // done wins over a timeout landing in the same cycle
                if (dut_done) begin
                    if (OUT_BEATS == 1) state_nxt_s = ST_IDLE;
                    else                state_nxt_s = ST_COLLECT;
                end else if (to_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_COLLECT: begin
                if (col_last_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_COLLECT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Config registers, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_r       <= {IN_W{1'b0}};
            trg_delay_r <= 8'd0;
            trg_width_r <= 8'd1;
            to_limit_r  <= {TO_W{1'b0}};
        end else if (cfg_acc_s) begin
            case (cfg_addr)
                ADDR_OPS:  ops_r       <= cfg_data;
                ADDR_TDLY: trg_delay_r <= cfg_data[7:0];
                ADDR_TWID: trg_width_r <= cfg_data[7:0];
                ADDR_TO:   to_limit_r  <= cfg_data[TO_W-1:0];
                default:   ;
            endcase
        end
    end

    // Run datapath: operand shifting, timeout count, result collection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r           <= {IN_W{1'b0}};
            ib_cnt_r       <= {IB_W{1'b0}};
            ob_cnt_r       <= {OB_W{1'b0}};
            to_cnt_r       <= {TO_W{1'b0}};
            busy_r         <= 1'b0;
            dut_start_r    <= 1'b0;
            dut_in_r       <= {(NUM_IN*LANE_W){1'b0}};
            result_r       <= {OUT_W{1'b0}};
            result_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            dut_start_r    <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= (state_nxt_s != ST_IDLE);
            // count saturates so a long wait cannot wrap below the limit
            if ((state_r == ST_FEED || state_r == ST_WAIT) && (to_cnt_r != {TO_W{1'b1}}))
                to_cnt_r <= to_cnt_r + TO_W'(1);
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        dut_start_r <= 1'b1;
                        timeout_r   <= 1'b0;
                        ib_cnt_r    <= {IB_W{1'b0}};
                        to_cnt_r    <= TO_W'(1);
                        // beat 0 goes out directly; the shift regs hold the rest
                        for (int i = 0; i < NUM_IN; i++) begin
                            dut_in_r[LANE_W*i +: LANE_W] <= ops_r[OP_W*i + OP_W - LANE_W +: LANE_W];
                            sh_r[OP_W*i +: OP_W]         <= ops_r[OP_W*i +: OP_W] << LANE_W;
                        end
                    end
                end
                ST_FEED: begin
                    if (feed_last_s) begin
                        dut_in_r <= {(NUM_IN*LANE_W){1'b0}};
                    end else begin
                        ib_cnt_r <= ib_cnt_r + IB_W'(1);
                        for (int i = 0; i < NUM_IN; i++) begin
                            dut_in_r[LANE_W*i +: LANE_W] <= sh_r[OP_W*i + OP_W - LANE_W +: LANE_W];
                            sh_r[OP_W*i +: OP_W]         <= sh_r[OP_W*i +: OP_W] << LANE_W;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dut_done) begin
                        result_r <= (result_r << LANE_W) | OUT_W'(dut_out);
                        ob_cnt_r <= OB_W'(1);
                        if (OUT_BEATS == 1) result_valid_r <= 1'b1;
                    end else if (to_hit_s) begin
                        timeout_r <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    result_r <= (result_r << LANE_W) | OUT_W'(dut_out);
                    if (col_last_s) result_valid_r <= 1'b1;
                    else            ob_cnt_r <= ob_cnt_r + OB_W'(1);
                end
                default: ;
            endcase
        end
    end

    trig_pulse_gen u_trig (
        .clk   (clk),
        .rst   (rst),
        .arm   (start_acc_s),
        .delay (trg_delay_r),
        .width (trg_width_r),
        .trg   (trg)
    );

    assign busy         = busy_r;
    assign dut_start    = dut_start_r;
    assign dut_in       = dut_in_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_dut_stream_sequencer.sv
// Scoreboard bench for dut_stream_sequencer: an 8-bit-lane instance (u_a)
// and a 16-bit-lane instance (u_b). Stimulus pushes expected beats, trigger
// cycles and results into queues; monitors pop and compare on DUT outputs.
module tb_dut_stream_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: LANE_W = 8
    logic         cfg_we = 1'b0;
    logic [7:0]   cfg_addr = 8'd0;
    logic [255:0] cfg_data = 256'd0;
    logic         start = 1'b0;
    logic         dut_done = 1'b0;
    logic [7:0]   dut_out = 8'd0;
    logic         busy, dut_start, result_valid, trg, timeout;
    logic [15:0]  dut_in;
    logic [127:0] result;

    // instance B: LANE_W = 16
    logic         cfg_we_b = 1'b0;
    logic [7:0]   cfg_addr_b = 8'd0;
    logic [255:0] cfg_data_b = 256'd0;
    logic         start_b = 1'b0;
    logic         dut_done_b = 1'b0;
    logic [15:0]  dut_out_b = 16'd0;
    logic         busy_b, dut_start_b, result_valid_b, trg_b, timeout_b;
    logic [31:0]  dut_in_b;
    logic [127:0] result_b;

    dut_stream_sequencer #(.OP_BYTES(16), .NUM_IN(2), .LANE_W(8), .OUT_BYTES(16), .TO_W(16)) u_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .busy(busy), .dut_start(dut_start), .dut_in(dut_in),
        .dut_done(dut_done), .dut_out(dut_out), .result(result), .result_valid(result_valid),
        .trg(trg), .timeout(timeout));

    dut_stream_sequencer #(.OP_BYTES(16), .NUM_IN(2), .LANE_W(16), .OUT_BYTES(16), .TO_W(16)) u_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_data(cfg_data_b),
        .start(start_b), .busy(busy_b), .dut_start(dut_start_b), .dut_in(dut_in_b),
        .dut_done(dut_done_b), .dut_out(dut_out_b), .result(result_b), .result_valid(result_valid_b),
        .trg(trg_b), .timeout(timeout_b));

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] RES = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

    logic [127:0] pt  = PT;
    logic [127:0] key = KEY;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int           c;
        logic [127:0] v;
    } exp_t;

    exp_t q_in[$];
    exp_t q_res[$];
    exp_t q_in_b[$];
    exp_t q_res_b[$];
    int   q_start[$];
    int   q_trg[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic spurious(input string nm);
        n_total++;
        $display("FAIL %s: output seen with no expectation queued (cycle %0d)", nm, cyc);
    endtask

    // monitor for instance A
    int   feed_left = 0;
    int   mc;
    exp_t me;
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_start) begin
                if (q_start.size() == 0) spurious("dut_start");
                else begin
                    mc = q_start.pop_front();
                    chk("dut_start cycle", 128'(cyc), 128'(mc));
                end
                feed_left = 17;
            end
            if (feed_left > 0) begin
                feed_left--;
                if (q_in.size() == 0) spurious("dut_in");
                else begin
                    me = q_in.pop_front();
                    chk("dut_in cycle", 128'(cyc), 128'(me.c));
                    chk("dut_in beat", 128'(dut_in), me.v);
                end
            end
            if (result_valid) begin
                if (q_res.size() == 0) spurious("result_valid");
                else begin
                    me = q_res.pop_front();
                    chk("result_valid cycle", 128'(cyc), 128'(me.c));
                    chk("result value", result, me.v);
                end
            end
            if (trg) begin
                if (q_trg.size() == 0) spurious("trg");
                else begin
                    mc = q_trg.pop_front();
                    chk("trg cycle", 128'(cyc), 128'(mc));
                end
            end
        end
    end

    // monitor for instance B
    int   feed_left_b = 0;
    exp_t me_b;
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_start_b) feed_left_b = 9;
            if (feed_left_b > 0) begin
                feed_left_b--;
                if (q_in_b.size() == 0) spurious("dut_in_b");
                else begin
                    me_b = q_in_b.pop_front();
                    chk("dut_in_b cycle", 128'(cyc), 128'(me_b.c));
                    chk("dut_in_b beat", 128'(dut_in_b), me_b.v);
                end
            end
            if (result_valid_b) begin
                if (q_res_b.size() == 0) spurious("result_valid_b");
                else begin
                    me_b = q_res_b.pop_front();
                    chk("result_valid_b cycle", 128'(cyc), 128'(me_b.c));
                    chk("result_b value", result_b, me_b.v);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [255:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic push_feed(input int s);
        for (int k = 0; k < 16; k++)
            q_in.push_back('{c: s + 1 + k, v: 128'({key[127-8*k -: 8], pt[127-8*k -: 8]})});
        q_in.push_back('{c: s + 17, v: 128'd0});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " busy"}, 128'(busy), 128'd0);
        chk({tag, " dut_start"}, 128'(dut_start), 128'd0);
        chk({tag, " dut_in"}, 128'(dut_in), 128'd0);
        chk({tag, " result"}, result, 128'd0);
        chk({tag, " result_valid"}, 128'(result_valid), 128'd0);
        chk({tag, " trg"}, 128'(trg), 128'd0);
        chk({tag, " timeout"}, 128'(timeout), 128'd0);
    endtask

    int s;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick(); tick();

        // run 1: full transaction, trigger delay 5 width 3
        cfg_wr(8'h01, {key, pt});
        cfg_wr(8'h02, 256'd5);
        cfg_wr(8'h03, 256'd3);
        s = cyc;
        start = 1'b1;
        q_start.push_back(s + 1);
        push_feed(s);
        q_trg.push_back(s + 6); q_trg.push_back(s + 7); q_trg.push_back(s + 8);
        q_res.push_back('{c: s + 46, v: RES});
        tick();
        start = 1'b0;
        chk("busy after start", 128'(busy), 128'd1);
        wait_until(s + 10);
        cfg_wr(8'h01, {256{1'b1}});      // must be ignored while busy
        wait_until(s + 12);
        start = 1'b1;                    // must be ignored while busy
        tick();
        start = 1'b0;
        wait_until(s + 30);
        dut_done = 1'b1; dut_out = 8'ha0;
        tick();
        dut_done = 1'b0;
        for (int i = 1; i < 16; i++) begin
            dut_out = 8'(8'ha0 + i);
            tick();
        end
        dut_out = 8'd0;
        chk("busy after run1", 128'(busy), 128'd0);
        tick(); tick(); tick();

        // run 2: no trigger pulse, DUT never answers -> timeout at S+21
        cfg_wr(8'h03, 256'd0);
        cfg_wr(8'h04, 256'd20);
        s = cyc;
        start = 1'b1;
        q_start.push_back(s + 1);
        push_feed(s);
        tick();
        start = 1'b0;
        wait_until(s + 20);
        chk("timeout before limit", 128'(timeout), 128'd0);
        chk("busy before limit", 128'(busy), 128'd1);
        tick();
        chk("timeout at limit", 128'(timeout), 128'd1);
        chk("busy at limit", 128'(busy), 128'd0);
        chk("result kept on timeout", result, RES);
        tick(); tick();
        chk("timeout sticky", 128'(timeout), 128'd1);

        // run 3: start with same-cycle operand write, trg delay 0 width 1,
        // then reset in the middle of COLLECT
        cfg_wr(8'h02, 256'd0);
        cfg_wr(8'h03, 256'd1);
        cfg_wr(8'h04, 256'd0);
        s = cyc;
        start = 1'b1;
        cfg_we = 1'b1; cfg_addr = 8'h01; cfg_data = {256{1'b1}};
        q_start.push_back(s + 1);
        push_feed(s);                    // old operands expected
        q_trg.push_back(s + 1);
        tick();
        start = 1'b0; cfg_we = 1'b0;
        chk("timeout cleared by start", 128'(timeout), 128'd0);
        wait_until(s + 30);
        dut_done = 1'b1; dut_out = 8'hb0;
        tick();
        dut_done = 1'b0;
        for (int i = 1; i < 5; i++) begin
            dut_out = 8'(8'hb0 + i);
            tick();
        end
        rst = 1'b1;
        #2;
        check_all_zero("mid-collect reset");
        dut_out = 8'd0;
        tick();
        rst = 1'b0;
        tick(); tick();

        // instance B: 16-bit lanes, 8 input beats, 8 output beats
        cfg_we_b = 1'b1; cfg_addr_b = 8'h01; cfg_data_b = {key, pt};
        tick();
        cfg_we_b = 1'b0;
        s = cyc;
        start_b = 1'b1;
        for (int k = 0; k < 8; k++)
            q_in_b.push_back('{c: s + 1 + k, v: 128'({key[127-16*k -: 16], pt[127-16*k -: 16]})});
        q_in_b.push_back('{c: s + 9, v: 128'd0});
        q_res_b.push_back('{c: s + 38, v: RES});
        tick();
        start_b = 1'b0;
        wait_until(s + 30);
        dut_done_b = 1'b1; dut_out_b = 16'ha0a1;
        tick();
        dut_done_b = 1'b0;
        for (int i = 1; i < 8; i++) begin
            dut_out_b = {8'(8'ha0 + 2 * i), 8'(8'ha1 + 2 * i)};
            tick();
        end
        dut_out_b = 16'd0;
        tick(); tick(); tick();

        chk("dut_start left unseen", 128'(q_start.size()), 128'd0);
        chk("dut_in beats left unseen", 128'(q_in.size()), 128'd0);
        chk("trg pulses left unseen", 128'(q_trg.size()), 128'd0);
        chk("results left unseen", 128'(q_res.size()), 128'd0);
        chk("dut_in_b beats left unseen", 128'(q_in_b.size()), 128'd0);
        chk("results_b left unseen", 128'(q_res_b.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
